des_decrypt_iter: RTL and testbench
===================================

Name: des_decrypt_iter

Overview:
- Iterative single-block DES decryptor: the inverse direction of the existing 16-stage pipelined DES encryptor.
- Accepts one 64-bit ciphertext and a 64-bit key over a valid/ready handshake. Runs the 16 Feistel rounds one per cycle with subkeys applied K16 first, down to K1.
- Returns the 64-bit plaintext over a valid/ready handshake.
- Trades throughput (one block per 18+ cycles) for area: one round datapath instead of sixteen.

Parameters:
- None. DES widths are fixed (64-bit block, 64-bit key, 48-bit subkey, 16 rounds).

Ports:
- CLK  input  1  rising-edge clock
- RST_N  input  1  asynchronous active-low reset
- in_valid  input  1  ciphertext/key offered
- in_ready  output  1  block can accept; high only in IDLE
- in_data  input  64  ciphertext, bit 63 = DES bit 1
- in_key  input  64  key incl. parity bits, bit 63 = DES bit 1; parity ignored
- out_valid  output  1  plaintext available
- out_ready  input  1  consumer takes plaintext
- out_data  output  64  plaintext
- busy  output  1  high in RUN

Behaviour:
- Reset (RST_N low, asynchronous, any state, including mid-operation):
  - state = IDLE; the round in progress is discarded.
  - in_ready = 1, out_valid = 0, busy = 0.
  - L/R and C/D registers = 0, round counter = 0.
  - out_data = IP_inv(0) = 0.
- States: IDLE, RUN, DONE. Registered state, L[31:0], R[31:0], C[27:0], D[27:0], round counter rnd[4:0].
- IDLE, edge with in_valid && in_ready:
  - {L,R} <= IP(in_data); {C,D} <= PC1(in_key); rnd <= 1; state <= RUN.
  - in_data and in_key are sampled only on this edge; later changes are ignored.
- RUN, each edge performs one round:
  - Subkey = PC2({C,D}).
  - L <= R; R <= L ^ f(R, subkey).
  - C/D rotate right by 1 when rnd is 1, 8 or 15; by 2 for rnd 2–7 and 9–14; no rotation when rnd is 16.
  - rnd <= rnd+1.
  - This produces subkeys K16, K15, … K1. C16 = C0, so no pre-rotation is needed.
- RUN to DONE: on the edge where rnd == 16 (the 16th round), state <= DONE.
- DONE:
  - out_valid = 1.
  - out_data = IP_inv({R,L}), i.e. the final swap is undone, preoutput R16||L16.
  - out_data is combinational from the registers and stays stable while out_valid && !out_ready.
- DONE, edge with out_ready: state <= IDLE.
  - in_ready rises the following cycle; there is no same-cycle accept in DONE.
- Latency:
  - out_valid rises exactly 17 edges after the accepting edge (1 load edge + 16 round edges).
  - Minimum block-to-block spacing: 18 cycles with out_ready held high.
- in_valid during RUN or DONE is ignored (in_ready = 0). The source must hold its data until accepted.
- out_ready while out_valid = 0 has no effect.
- Bit numbering follows FIPS 46-3 with DES bit 1 = MSB. All permutation and S-box tables are identical to those used by the encryptor.

Optional Feature:
- Macro: DES_ITER_MODE_EN.
- Defined:
  - Adds input port in_encrypt (1 bit), sampled on the accepting edge into a mode flag.
  - Mode flag = 1: C/D are pre-rotated left by 1 at load (C1/D1). Each round rotates left by the encrypt schedule (1 after rounds 1, 8, 15, with no rotation after 16; 2 otherwise). Subkeys run K1..K16 and the block encrypts.
  - Latency and handshake are unchanged.
- Undefined: no in_encrypt port; the block is decrypt-only exactly as described above.

Decomposition:
- Shared package des_pkg:
  - Tables: IP, IP_inv, E, P, PC1, PC2, S1–S8, and the 16-entry shift-schedule constant.
  - Permutation functions built from those tables.
  - State enum typedef {IDLE, RUN, DONE}.
- One sub-module: des_round_comb. Combinational L/R step plus PC2 subkey derivation from {C,D}; reused by any iterative DES core.

Test Plan:
- Reset mid-RUN: accept a block, pulse RST_N low at round 7 -> out_valid = 0, in_ready = 1, out_data = 0 asynchronously. A new block then decrypts correctly.
- FIPS vector: key 133457799BBCDFF1, in_data 85E813540F0AB405, out_ready = 1 -> out_valid 17 edges after accept, out_data 0123456789ABCDEF, busy high for 16 cycles.
- Zero vector: key 0000000000000000, in_data 8CA64DE9C1B123A7 -> out_data 0000000000000000.
- Backpressure: out_ready = 0 for 10 cycles after out_valid -> out_data constant, in_ready = 0, second in_valid ignored. Raising out_ready -> IDLE next edge, queued block then accepted.
- Back-to-back: 4 random key/plaintext pairs encrypted by the pipelined encryptor, fed with in_valid held high -> plaintexts match in order, spacing 18 cycles. Input changes during RUN do not corrupt results.
- Mode feature (DES_ITER_MODE_EN): in_encrypt = 1, key 133457799BBCDFF1, in_data 0123456789ABCDEF -> out_data 85E813540F0AB405.

Source files
------------

// File: rtl/des_pkg.sv
// Shared DES tables, permutation helpers and control-state type for iterative DES cores.
// Bit numbering follows FIPS 46-3 (DES bit 1 = vector MSB).
package des_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

    localparam int IP_INV_T [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};

    localparam int E_T [48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

    localparam int P_T [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    // Left-rotation amount before computing subkey K(i+1).
    localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    localparam int SBOX_T [8][64] = '{
        '{14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,
          0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
          4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,
          15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13},
        '{15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,
          3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
          0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,
          13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9},
        '{10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,
          13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
          13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,
          1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12},
        '{7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,
          13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
          10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,
          3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14},
        '{2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,
          14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
          4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,
          11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3},
        '{12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,
          10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
          9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,
          4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13},
        '{4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,
          13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
          1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,
          6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12},
        '{13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,
          1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
          7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,
          2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11}};

    function automatic logic [63:0] ip(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - IP_T[i])];
        return y;
    endfunction

    function automatic logic [63:0] ip_inv(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - IP_INV_T[i])];
        return y;
    endfunction

    function automatic logic [47:0] e_exp(input logic [31:0] x);
        logic [47:0] y;
        y = '0;
        for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[5'(32 - E_T[i])];
        return y;
    endfunction

    function automatic logic [31:0] p_perm(input logic [31:0] x);
        logic [31:0] y;
        y = '0;
        for (int i = 0; i < 32; i++) y[5'(31 - i)] = x[5'(32 - P_T[i])];
        return y;
    endfunction

    function automatic logic [55:0] pc1(input logic [63:0] x);
        logic [55:0] y;
        y = '0;
        for (int i = 0; i < 56; i++) y[6'(55 - i)] = x[6'(64 - PC1_T[i])];
        return y;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] x);
        logic [47:0] y;
        y = '0;
        for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[6'(56 - PC2_T[i])];
        return y;
    endfunction

    // Row is {b1,b6}, column is b2..b5, so the flat index is just a bit reorder.
    function automatic logic [3:0] sbox(input logic [2:0] box, input logic [5:0] b);
        return 4'(SBOX_T[box][{b[5], b[0], b[4:1]}]);
    endfunction

    function automatic logic [27:0] rot_right(input logic [27:0] x, input logic [1:0] n);
        case (n)
            2'd1:    return {x[0], x[27:1]};
            2'd2:    return {x[1:0], x[27:2]};
            default: return x;
        endcase
    endfunction

    function automatic logic [27:0] rot_left(input logic [27:0] x, input logic [1:0] n);
        case (n)
            2'd1:    return {x[26:0], x[27]};
            2'd2:    return {x[25:0], x[27:26]};
            default: return x;
        endcase
    endfunction

    // The schedule is palindromic past its first entry, so one lookup serves both
    // the right-rotating decrypt walk and the left-rotating encrypt walk.
    function automatic logic [1:0] round_shift(input logic [4:0] rnd);
        if (rnd >= 5'd1 && rnd <= 5'd15) return 2'(SHIFTS[4'(rnd)]);
        return 2'd0;
    endfunction

endpackage

// File: rtl/des_round_comb.sv
// One combinational DES Feistel round: PC2 subkey from {C,D}, then L/R update.
module des_round_comb
    import des_pkg::*;
(
    input  logic [31:0] l,
    input  logic [31:0] r,
    input  logic [27:0] c,
    input  logic [27:0] d,
    output logic [31:0] l_next,
    output logic [31:0] r_next
);

    logic [47:0] subkey;
    logic [47:0] mixed;
    logic [31:0] sbox_out;

    always_comb begin
        subkey   = pc2({c, d});
        mixed    = e_exp(r) ^ subkey;
        sbox_out = '0;
        for (int i = 0; i < 8; i++)
            sbox_out[5'(31 - 4 * i) -: 4] = sbox(3'(i), mixed[6'(47 - 6 * i) -: 6]);
        l_next = r;
        r_next = l ^ p_perm(sbox_out);
    end

endmodule

// File: rtl/des_decrypt_iter.sv
// Iterative single-block DES decryptor, one Feistel round per cycle, subkeys K16 down to K1.
// Define DES_ITER_MODE_EN to add an in_encrypt port selecting the K1..K16 encrypt walk.
module des_decrypt_iter
    import des_pkg::*;
(
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    input  logic [63:0] in_key,
`ifdef DES_ITER_MODE_EN
    input  logic        in_encrypt,
`endif
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic        busy
);

    state_t      state, state_next;
    logic [31:0] l, r;
    logic [27:0] c, d;
    logic [4:0]  rnd;
    logic [31:0] l_next, r_next;
    logic [27:0] c_next, d_next;
    logic [55:0] cd_load;
    logic [1:0]  shift;
`ifdef DES_ITER_MODE_EN
    logic        mode;
`endif

    des_round_comb u_round (
        .l      (l),
        .r      (r),
        .c      (c),
        .d      (d),
        .l_next (l_next),
        .r_next (r_next)
    );

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        busy       = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (rnd == 5'd16) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // C16 equals C0, so decryption starts from PC1 output and walks right.
    always_comb begin
        cd_load = pc1(in_key);
        shift   = round_shift(rnd);
        c_next  = rot_right(c, shift);
        d_next  = rot_right(d, shift);
`ifdef DES_ITER_MODE_EN
        if (mode) begin
            c_next = rot_left(c, shift);
            d_next = rot_left(d, shift);
        end
`endif
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
            l     <= '0;
            r     <= '0;
            c     <= '0;
            d     <= '0;
            rnd   <= '0;
`ifdef DES_ITER_MODE_EN
            mode  <= 1'b0;
`endif
        end else begin
            state <= state_next;
            if (state == IDLE && in_valid) begin
                {l, r} <= ip(in_data);
                c      <= cd_load[55:28];
                d      <= cd_load[27:0];
                rnd    <= 5'd1;
`ifdef DES_ITER_MODE_EN
                mode   <= in_encrypt;
                if (in_encrypt) begin
                    c <= rot_left(cd_load[55:28], 2'd1);
                    d <= rot_left(cd_load[27:0], 2'd1);
                end
`endif
            end else if (state == RUN) begin
                l   <= l_next;
                r   <= r_next;
                c   <= c_next;
                d   <= d_next;
                rnd <= rnd + 5'd1;
            end
        end
    end

    // Preoutput is R16||L16: the last round's swap is undone here.
    assign out_data = ip_inv({r, l});

endmodule

// File: tb/tb_des_decrypt_iter.sv
// Self-checking bench for des_decrypt_iter against a full-schedule DES reference model.
module tb_des_decrypt_iter;
    import des_pkg::*;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_data = '0;
    logic [63:0] in_key = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_data;
    logic        busy;
`ifdef DES_ITER_MODE_EN
    logic        in_encrypt = 1'b0;
`endif

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    des_decrypt_iter dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_key    (in_key),
`ifdef DES_ITER_MODE_EN
        .in_encrypt(in_encrypt),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Textbook DES: all sixteen subkeys up front with left rotations, then pick the order.
    function automatic logic [63:0] des_model(input logic [63:0] key, input logic [63:0] blk,
                                              input bit encrypt);
        logic [47:0] ks [16];
        logic [55:0] cd;
        logic [27:0] c, d;
        logic [63:0] x;
        logic [47:0] ex;
        logic [31:0] l, r, s, t;
        cd = pc1(key);
        c = cd[55:28];
        d = cd[27:0];
        for (int i = 0; i < 16; i++) begin
            for (int k = 0; k < SHIFTS[i]; k++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            ks[i] = pc2({c, d});
        end
        x = ip(blk);
        l = x[63:32];
        r = x[31:0];
        for (int i = 0; i < 16; i++) begin
            ex = e_exp(r) ^ ks[encrypt ? i : 15 - i];
            s = '0;
            for (int b = 0; b < 8; b++) s[31 - 4 * b -: 4] = sbox(3'(b), ex[47 - 6 * b -: 6]);
            t = l ^ p_perm(s);
            l = r;
            r = t;
        end
        return ip_inv({r, l});
    endfunction

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    // Offer a block, wait for acceptance, scramble inputs during RUN, wait for the result.
    task automatic do_block(input logic [63:0] key, input logic [63:0] blk, input logic [63:0] exp,
                            input string tag, input bit hold, output int acc_cyc);
        int n;
        int lat;
        int bcnt;
        in_valid = 1'b1;
        in_key   = key;
        in_data  = blk;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge CLK); #1;
            n++;
        end
        check({tag, "_accept"}, {63'd0, in_ready}, 64'd1);
        @(posedge CLK); #1;
        acc_cyc  = cyc;
        in_valid = hold;
        in_key   = rand64();
        in_data  = rand64();
        lat  = 1;
        bcnt = 0;
        while (!out_valid && lat < 40) begin
            if (busy) bcnt++;
            @(posedge CLK); #1;
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'd17);
        check({tag, "_busy_cycles"}, 64'(bcnt), 64'd16);
        check({tag, "_in_ready_done"}, {63'd0, in_ready}, 64'd0);
        check({tag, "_data"}, out_data, exp);
    endtask

    initial begin
        int a0, a1;
        logic [63:0] k, p, k2, p2, held;

        // Reset state
        repeat (2) @(posedge CLK);
        #1;
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_out_data", out_data, 64'd0);
        #2 RST_N = 1'b1;
        @(posedge CLK); #1;

        // Known answer vectors
        out_ready = 1'b1;
        do_block(64'h133457799BBCDFF1, 64'h85E813540F0AB405, 64'h0123456789ABCDEF, "fips", 1'b0, a0);
        @(posedge CLK); #1;
        check("fips_back_idle", {63'd0, in_ready}, 64'd1);
        check("fips_out_valid_drop", {63'd0, out_valid}, 64'd0);
        do_block(64'h0, 64'h8CA64DE9C1B123A7, 64'h0, "zero", 1'b0, a0);
        @(posedge CLK); #1;

        // Asynchronous reset during round 7
        in_valid = 1'b1;
        in_key   = rand64();
        in_data  = rand64();
        @(posedge CLK); #1;
        in_valid = 1'b0;
        repeat (6) @(posedge CLK);
        #1;
        check("midrun_busy", {63'd0, busy}, 64'd1);
        #2 RST_N = 1'b0;
        #1;
        check("midrun_rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("midrun_rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("midrun_rst_busy", {63'd0, busy}, 64'd0);
        check("midrun_rst_out_data", out_data, 64'd0);
        #2 RST_N = 1'b1;
        @(posedge CLK); #1;
        k = rand64();
        p = rand64();
        do_block(k, des_model(k, p, 1'b1), p, "after_rst", 1'b0, a0);
        @(posedge CLK); #1;

        // Backpressure with a second block queued
        out_ready = 1'b0;
        k  = rand64();
        p  = rand64();
        k2 = rand64();
        p2 = rand64();
        do_block(k, des_model(k, p, 1'b1), p, "bp", 1'b0, a0);
        held     = out_data;
        in_valid = 1'b1;
        in_key   = k2;
        in_data  = des_model(k2, p2, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(posedge CLK); #1;
            check("bp_hold_data", out_data, p);
            check("bp_in_ready", {63'd0, in_ready}, 64'd0);
            check("bp_out_valid", {63'd0, out_valid}, 64'd1);
        end
        check("bp_stable", out_data, held);
        out_ready = 1'b1;
        @(posedge CLK); #1;
        check("bp_release_idle", {63'd0, in_ready}, 64'd1);
        check("bp_release_valid", {63'd0, out_valid}, 64'd0);
        do_block(k2, des_model(k2, p2, 1'b1), p2, "bp_queued", 1'b0, a0);
        @(posedge CLK); #1;

        // Back-to-back with in_valid held high
        a1 = 0;
        for (int i = 0; i < 4; i++) begin
            k = rand64();
            p = rand64();
            do_block(k, des_model(k, p, 1'b1), p, $sformatf("b2b%0d", i), 1'b1, a0);
            if (i > 0) check($sformatf("b2b%0d_spacing", i), 64'(a0 - a1), 64'd18);
            a1 = a0;
        end
        in_valid = 1'b0;
        @(posedge CLK); #1;

        // A few extra random decrypts with gaps
        for (int i = 0; i < 3; i++) begin
            k = rand64();
            p = rand64();
            do_block(k, des_model(k, p, 1'b1), p, $sformatf("rnd%0d", i), 1'b0, a0);
            repeat ($urandom_range(1, 4)) @(posedge CLK);
            #1;
        end

`ifdef DES_ITER_MODE_EN
        // Encrypt mode
        in_encrypt = 1'b1;
        do_block(64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 64'h85E813540F0AB405, "enc_fips", 1'b0, a0);
        @(posedge CLK); #1;
        for (int i = 0; i < 2; i++) begin
            k = rand64();
            p = rand64();
            in_encrypt = 1'b1;
            do_block(k, p, des_model(k, p, 1'b1), $sformatf("enc%0d", i), 1'b0, a0);
            @(posedge CLK); #1;
        end
        in_encrypt = 1'b0;
        k = rand64();
        p = rand64();
        do_block(k, des_model(k, p, 1'b1), p, "dec_after_enc", 1'b0, a0);
        @(posedge CLK); #1;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
